// File: rtl/struct_sig_reader.sv
// struct_sig_reader
//   Samples the packed {x, y, z} signal struct, requires each new value to
//   hold for SETTLE consecutive sampled cycles before committing it, and
//   queues every committed value in a small first-word-fall-through FIFO.
//   A downstream consumer drains the FIFO through out_valid/out_ready.
//
// Ports
//   clk, rst        : single clock, synchronous active-high reset
//   sig_i[2:0]      : incoming struct {x, y, z}, x = bit 2
//   out_valid       : FIFO holds at least one event
//   out_ready       : consumer takes the head entry this cycle
//   out_sig[2:0]    : head entry (0 while empty), out_x/out_y/out_z = fields
//   committed[2:0]  : last committed value
//   level           : FIFO occupancy, reads DEPTH when full
//   overflow        : sticky, an event was dropped on a full FIFO
//   glitch_cnt[7:0] : saturating count of aborted candidates
module struct_sig_reader #(
    parameter int SETTLE = 10,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             sig_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2:0]             out_sig,
    output logic                   out_x,
    output logic                   out_y,
    output logic                   out_z,
    output logic [2:0]             committed,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [7:0]             glitch_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [7:0]    LAST = 8'(SETTLE - 1);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    typedef struct packed {
        logic x;
        logic y;
        logic z;
    } sig_t;

    typedef enum logic {IDLE, SETTLING} state_t;

    state_t        state, state_n;
    logic [2:0]    sig_q;
    logic [2:0]    cand, cand_n;
    logic [7:0]    cnt, cnt_n;
    logic          commit;
    logic          glitch;

    sig_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full;
    logic          do_push, do_pop;
    sig_t          head;

    // ---------------------------------------------------------------
    // Settle FSM: next state and datapath strobes
    // ---------------------------------------------------------------
    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        commit  = 1'b0;
        glitch  = 1'b0;
        case (state)
            IDLE: begin
                if (sig_q != committed) begin
                    cand_n  = sig_q;
                    cnt_n   = 8'd1;
                    state_n = SETTLING;
                end
            end
            SETTLING: begin
                if (sig_q == cand) begin
                    if (cnt == LAST) begin
                        commit  = 1'b1;
                        cnt_n   = 8'd0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end else begin
                    glitch = 1'b1;
                    // Falling back to the committed value is not a new event.
                    if (sig_q == committed) begin
                        cnt_n   = 8'd0;
                        state_n = IDLE;
                    end else begin
                        cand_n = sig_q;
                        cnt_n  = 8'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sig_q <= 3'b000;
            cand  <= 3'b000;
            cnt   <= 8'd0;
        end else begin
            state <= state_n;
            sig_q <= sig_i;
            cand  <= cand_n;
            cnt   <= cnt_n;
        end
    end

    // ---------------------------------------------------------------
    // Event FIFO
    // ---------------------------------------------------------------
    assign full      = (level == FULL);
    assign out_valid = (level != '0);
    assign do_pop    = out_valid && out_ready;
    // A full FIFO still accepts the push when the head leaves this cycle.
    assign do_push   = commit && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= sig_t'(cand);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            committed  <= 3'b000;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            glitch_cnt <= 8'd0;
        end else begin
            if (commit) committed <= cand;
            if (commit && full && !do_pop) overflow <= 1'b1;
            if (glitch && glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Head is forced to zero while empty so stale entries never show.
    assign head    = out_valid ? mem[rd_ptr] : '0;
    assign out_sig = head;
    assign out_x   = head.x;
    assign out_y   = head.y;
    assign out_z   = head.z;

endmodule

// File: tb/tb_struct_sig_reader.sv
module tb_struct_sig_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sig_i;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_sig;
    logic       out_x, out_y, out_z;
    logic [2:0] committed;
    logic [2:0] level;
    logic       overflow;
    logic [7:0] glitch_cnt;

    int total = 0;
    int bad   = 0;
    logic [2:0] exp_q [$];

    struct_sig_reader #(.SETTLE(10), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_i      (sig_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sig    (out_sig),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_z      (out_z),
        .committed  (committed),
        .level      (level),
        .overflow   (overflow),
        .glitch_cnt (glitch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // inputs change and outputs are sampled on the falling edge
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // hold a value long enough to commit and record the expected event
    task automatic put(input logic [2:0] v);
        sig_i = v;
        exp_q.push_back(v);
        cyc(11);
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 20) begin
            if (out_valid) chk({tag, "_pop"}, 32'(out_sig), 32'(exp_q.pop_front()));
            cyc(1);
            guard++;
        end
        out_ready = 1'b0;
        chk({tag, "_left"}, exp_q.size(), 0);
        chk({tag, "_lvl"}, 32'(level), 0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        cyc(n);
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        sig_i = 3'b000;
        out_ready = 1'b0;
        rst = 1'b1;
        cyc(1);
        do_reset(2);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_glitch", 32'(glitch_cnt), 0);
        chk("rst_comm", 32'(committed), 0);
        chk("rst_sig", 32'({out_sig, out_x, out_y, out_z}), 0);
        cyc(12);
        chk("zero_noevt", 32'(out_valid), 0);

        // 1: single change, exact latency
        sig_i = 3'b101;
        cyc(10);
        chk("t1_early", 32'(out_valid), 0);
        cyc(1);
        exp_q.push_back(3'b101);
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_sig", 32'(out_sig), 32'h5);
        chk("t1_xyz", 32'({out_x, out_y, out_z}), 32'h5);
        chk("t1_comm", 32'(committed), 32'h5);
        chk("t1_level", 32'(level), 1);

        // 2: glitch back to the committed value
        sig_i = 3'b011;
        cyc(4);
        sig_i = 3'b101;
        cyc(14);
        chk("t2_glitch", 32'(glitch_cnt), 1);
        chk("t2_level", 32'(level), 1);
        chk("t2_comm", 32'(committed), 32'h5);
        drain("t2");

        // 3: candidate replaced before settling
        do_reset(1);
        sig_i = 3'b001;
        cyc(3);
        sig_i = 3'b110;
        cyc(10);
        chk("t3_early", 32'(out_valid), 0);
        cyc(1);
        exp_q.push_back(3'b110);
        chk("t3_valid", 32'(out_valid), 1);
        chk("t3_glitch", 32'(glitch_cnt), 1);
        cyc(12);
        chk("t3_level", 32'(level), 1);
        drain("t3");

        // 4: overflow, the fifth event is dropped
        put(3'b001);
        put(3'b010);
        put(3'b011);
        put(3'b100);
        chk("t4_ovf0", 32'(overflow), 0);
        sig_i = 3'b101;
        cyc(11);
        chk("t4_level", 32'(level), 4);
        chk("t4_ovf", 32'(overflow), 1);
        chk("t4_comm", 32'(committed), 32'h5);
        drain("t4");

        // 5: push and pop in the same cycle while full
        do_reset(1);
        put(3'b001);
        put(3'b010);
        put(3'b011);
        put(3'b100);
        chk("t5_full", 32'(level), 4);
        sig_i = 3'b111;
        exp_q.push_back(3'b111);
        cyc(10);
        out_ready = 1'b1;
        chk("t5_head", 32'(out_sig), 32'(exp_q.pop_front()));
        cyc(1);
        out_ready = 1'b0;
        chk("t5_level", 32'(level), 4);
        chk("t5_ovf", 32'(overflow), 0);
        chk("t5_comm", 32'(committed), 32'h7);
        drain("t5");

        // 6: reset with queued events and a candidate in flight
        sig_i = 3'b000;
        cyc(2);
        sig_i = 3'b111;
        cyc(3);
        put(3'b001);
        put(3'b011);
        chk("t6_pre_lvl", 32'(level), 2);
        chk("t6_pre_gl", 32'(glitch_cnt), 1);
        sig_i = 3'b010;
        cyc(7);
        do_reset(1);
        chk("t6_level", 32'(level), 0);
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_ovf", 32'(overflow), 0);
        chk("t6_glitch", 32'(glitch_cnt), 0);
        chk("t6_comm", 32'(committed), 0);
        cyc(10);
        chk("t6_early", 32'(out_valid), 0);
        cyc(1);
        exp_q.push_back(3'b010);
        chk("t6_valid2", 32'(out_valid), 1);
        drain("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
